grf_wport_arb: RTL



---
 rtl/grf_wport_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/grf_wport_arb.sv
// GRF write-port arbiter: W-stage writeback has priority, the aux requester is queued and
// protected from starvation. Define GRF_WARB_STATS_EN to add grant/stall counters.
module grf_wport_arb #(
   parameter int AUX_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_valid,
   input  logic [4:0]  w_addr,
   input  logic [31:0] w_data,
   input  logic [31:0] w_pc,
   output logic        w_ready,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   input  logic [31:0] a_pc,
   output logic        a_ready,
   output logic        grf_wen,
   output logic [4:0]  grf_addr,
   output logic [31:0] grf_data,
   output logic [31:0] grf_wpc,
   output logic [31:0] a_pend_mask,
   output logic        a_full
`ifdef GRF_WARB_STATS_EN
   ,
   output logic [31:0] stat_w_grants,
   output logic [31:0] stat_a_grants,
   output logic [31:0] stat_w_stalls
`endif
);

   localparam int PW = $clog2(AUX_DEPTH);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   localparam logic [0:0] PRIO_W  = 1'b0;
   localparam logic [0:0] FORCE_A = 1'b1;

   logic [4:0]           fifoAddr [AUX_DEPTH];
   logic [31:0]          fifoData [AUX_DEPTH];
   logic [31:0]          fifoPc   [AUX_DEPTH];
   logic [AUX_DEPTH-1:0] entValid, entValidNext;
   logic [PW:0]          wrPtr, rdPtr;
   logic [PW-1:0]        wrIdx, rdIdx;
   logic                 fifoEmpty, fifoFull;
   logic                 push, pop;
   logic [0:0]           state, stateNext;
   logic [CW-1:0]        starveCnt, cntNext;
   logic [31:0]          maskNext;
   logic [4:0]           slotAddr;

   assign wrIdx     = wrPtr[PW-1:0];
   assign rdIdx     = rdPtr[PW-1:0];
   assign fifoEmpty = (wrPtr == rdPtr);
   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign fifoFull  = (wrPtr[PW] != rdPtr[PW]) && (wrIdx == rdIdx);

   assign a_full  = fifoFull;
   assign a_ready = !fifoFull;
   assign w_ready = (state == PRIO_W) && w_valid;
   assign push    = a_valid && !fifoFull;
   assign pop     = !fifoEmpty && ((state == FORCE_A) || !w_valid);

   always_comb begin
      cntNext   = starveCnt;
      stateNext = PRIO_W;
      if (pop)
         cntNext = '0;
      else if (!fifoEmpty && (starveCnt != CNT_MAX))
         cntNext = starveCnt + 1'b1;
      if ((state == PRIO_W) && (cntNext == CNT_MAX))
         stateNext = FORCE_A;
   end

   // Pending mask is rebuilt per slot so duplicate addresses stay set until their last entry retires.
   always_comb begin
      entValidNext = entValid;
      maskNext     = '0;
      slotAddr     = '0;
      if (pop)  entValidNext[rdIdx] = 1'b0;
      if (push) entValidNext[wrIdx] = 1'b1;
      for (int i = 0; i < AUX_DEPTH; i++) begin
         slotAddr = (push && (wrIdx == PW'(i))) ? a_addr : fifoAddr[i];
         if (entValidNext[i] && (slotAddr != 5'd0))
            maskNext[slotAddr] = 1'b1;
      end
   end

   // NOTE: storage needs no reset; occupancy comes from the pointers and entValid alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoAddr[wrIdx] <= a_addr;
         fifoData[wrIdx] <= a_data;
         fifoPc[wrIdx]   <= a_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr       <= '0;
         rdPtr       <= '0;
         entValid    <= '0;
         state       <= PRIO_W;
         starveCnt   <= '0;
         a_pend_mask <= '0;
         grf_wen     <= 1'b0;
         grf_addr    <= '0;
         grf_data    <= '0;
         grf_wpc     <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         entValid    <= entValidNext;
         state       <= stateNext;
         starveCnt   <= cntNext;
         a_pend_mask <= maskNext;
         if (w_ready) begin
            grf_wen  <= (w_addr != 5'd0);
            grf_addr <= w_addr;
            grf_data <= w_data;
            grf_wpc  <= w_pc;
         end else if (pop) begin
            grf_wen  <= (fifoAddr[rdIdx] != 5'd0);
            grf_addr <= fifoAddr[rdIdx];
            grf_data <= fifoData[rdIdx];
            grf_wpc  <= fifoPc[rdIdx];
         end else begin
            grf_wen  <= 1'b0;
         end
      end
   end

`ifdef GRF_WARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_w_grants <= '0;
         stat_a_grants <= '0;
         stat_w_stalls <= '0;
      end else begin
         if (w_ready)              stat_w_grants <= stat_w_grants + 1'b1;
         if (pop)                  stat_a_grants <= stat_a_grants + 1'b1;
         if (w_valid && !w_ready)  stat_w_stalls <= stat_w_stalls + 1'b1;
      end
   end
`endif

endmodule
